// File: rtl/ascon_block_packer_pkg.sv
// Shared constants and state encoding for the Ascon byte-to-block packer.
package ascon_block_packer_pkg;

  localparam logic [7:0] ASCON_PAD_BYTE = 8'h80;
  localparam int RATE64  = 64;
  localparam int RATE128 = 128;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } packer_state_e;

endpackage

// File: rtl/ascon_block_packer_if.sv
// Byte-side and block-side handshake bundle of the Ascon block packer.
// With ASCON_PACKER_NOPAD_EN defined the bundle carries the per-message pad_en_i.
interface ascon_block_packer_if #(
  parameter int BLOCK_WIDTH = 64,
  parameter int CNT_W       = $clog2(BLOCK_WIDTH/8) + 1
);
  logic [7:0]             in_data_i;
  logic                   in_valid_i;
  logic                   in_last_i;
  logic                   in_empty_i;
  logic                   in_ready_o;
  logic [BLOCK_WIDTH-1:0] blk_o;
  logic                   blk_valid_o;
  logic                   blk_ready_i;
  logic                   blk_last_o;
  logic [CNT_W-1:0]       blk_nbytes_o;
`ifdef ASCON_PACKER_NOPAD_EN
  logic                   pad_en_i;
`endif

  modport slave (
`ifdef ASCON_PACKER_NOPAD_EN
    input  pad_en_i,
`endif
    input  in_data_i, in_valid_i, in_last_i, in_empty_i, blk_ready_i,
    output in_ready_o, blk_o, blk_valid_o, blk_last_o, blk_nbytes_o
  );

  modport master (
`ifdef ASCON_PACKER_NOPAD_EN
    output pad_en_i,
`endif
    output in_data_i, in_valid_i, in_last_i, in_empty_i, blk_ready_i,
    input  in_ready_o, blk_o, blk_valid_o, blk_last_o, blk_nbytes_o
  );
endinterface

// File: rtl/ascon_block_packer_byte_insert.sv
// ascon_byte_insert: writes a byte into slot 'slot' of a block and zeros every later slot.
// Slot indices at or beyond the block size leave the block unchanged.
module ascon_byte_insert #(
  parameter int BLOCK_WIDTH = 64,
  parameter int CNT_W       = $clog2(BLOCK_WIDTH/8) + 1
) (
  input  logic [BLOCK_WIDTH-1:0] blk_in,
  input  logic [CNT_W-1:0]       slot,
  input  logic [7:0]             byte_in,
  output logic [BLOCK_WIDTH-1:0] blk_out
);
  localparam int NB = BLOCK_WIDTH / 8;

  always_comb begin
    blk_out = blk_in;
    for (int k = 0; k < NB; k++) begin
      if (CNT_W'(k) == slot) begin
        blk_out[BLOCK_WIDTH-1-8*k -: 8] = byte_in;
      end else if (CNT_W'(k) > slot) begin
        blk_out[BLOCK_WIDTH-1-8*k -: 8] = 8'h00;
      end
    end
  end
endmodule

// File: rtl/ascon_block_packer.sv
// Streaming byte-to-block packer with Ascon 10* padding (rate 64 or 128 bits).
// Optional ASCON_PACKER_NOPAD_EN adds a per-message pad enable for key/nonce loading.
//
//   state    | meaning
//   FILL     | accepting message bytes into the block buffer
//   EMIT     | holding a completed data block for the consumer
//   EMIT_PAD | holding the extra all-padding block after a full last block
module ascon_block_packer
  import ascon_block_packer_pkg::*;
#(
  parameter int BLOCK_WIDTH = 64,
  parameter int CNT_W       = $clog2(BLOCK_WIDTH/8) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ascon_block_packer_if.slave  bus
);
  localparam int NB = BLOCK_WIDTH / 8;
  localparam logic [1:0] ST_FILL     = FILL;
  localparam logic [1:0] ST_EMIT     = EMIT;
  localparam logic [1:0] ST_EMIT_PAD = EMIT_PAD;
  localparam logic [CNT_W-1:0] NB_C = CNT_W'(NB);
  localparam logic [BLOCK_WIDTH-1:0] PAD_BLK = {ASCON_PAD_BYTE, {(BLOCK_WIDTH-8){1'b0}}};

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_after;
  logic [CNT_W-1:0]       nbytes_q;
  logic [BLOCK_WIDTH-1:0] blk_q;
  logic [BLOCK_WIDTH-1:0] data_blk;
  logic [BLOCK_WIDTH-1:0] base_blk;
  logic [BLOCK_WIDTH-1:0] pad_blk;
  logic                   last_q;
  logic                   pad_pending;
  logic                   accept;
  logic                   empty_beat;
  logic                   pad_en_eff;

  assign accept     = bus.in_valid_i && (state == ST_FILL);
  assign empty_beat = bus.in_last_i && bus.in_empty_i;
  assign cnt_after  = empty_beat ? cnt : cnt + 1'b1;
  assign base_blk   = empty_beat ? blk_q : data_blk;

  ascon_byte_insert #(.BLOCK_WIDTH(BLOCK_WIDTH), .CNT_W(CNT_W)) u_data_ins (
    .blk_in  (blk_q),
    .slot    (cnt),
    .byte_in (bus.in_data_i),
    .blk_out (data_blk)
  );

  ascon_byte_insert #(.BLOCK_WIDTH(BLOCK_WIDTH), .CNT_W(CNT_W)) u_pad_ins (
    .blk_in  (base_blk),
    .slot    (cnt_after),
    .byte_in (ASCON_PAD_BYTE),
    .blk_out (pad_blk)
  );

`ifdef ASCON_PACKER_NOPAD_EN
  // pad_en is latched on the first beat so mid-message toggles are ignored
  logic pad_en_q;
  logic msg_open;
  assign pad_en_eff = msg_open ? pad_en_q : bus.pad_en_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_en_q <= 1'b1;
      msg_open <= 1'b0;
    end else if (accept) begin
      msg_open <= !bus.in_last_i;
      if (!msg_open) pad_en_q <= bus.pad_en_i;
    end
  end
`else
  assign pad_en_eff = 1'b1;
`endif

  assign bus.in_ready_o   = (state == ST_FILL);
  assign bus.blk_valid_o  = (state == ST_EMIT) || (state == ST_EMIT_PAD);
  assign bus.blk_o        = blk_q;
  assign bus.blk_last_o   = last_q;
  assign bus.blk_nbytes_o = nbytes_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_FILL;
      cnt         <= '0;
      nbytes_q    <= '0;
      blk_q       <= '0;
      last_q      <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (!empty_beat && cnt_after == NB_C) begin
              blk_q    <= data_blk;
              nbytes_q <= NB_C;
              state    <= ST_EMIT;
              // a full last block defers the 10* padding to a block of its own
              if (bus.in_last_i && pad_en_eff) begin
                last_q      <= 1'b0;
                pad_pending <= 1'b1;
              end else begin
                last_q <= bus.in_last_i;
              end
            end else if (bus.in_last_i) begin
              blk_q    <= pad_en_eff ? pad_blk : base_blk;
              nbytes_q <= cnt_after;
              last_q   <= 1'b1;
              state    <= ST_EMIT;
            end else begin
              blk_q <= data_blk;
              cnt   <= cnt_after;
            end
          end
        end
        ST_EMIT: begin
          if (bus.blk_ready_i) begin
            if (pad_pending) begin
              blk_q    <= PAD_BLK;
              nbytes_q <= '0;
              last_q   <= 1'b1;
              state    <= ST_EMIT_PAD;
            end else begin
              blk_q    <= '0;
              cnt      <= '0;
              nbytes_q <= '0;
              last_q   <= 1'b0;
              state    <= ST_FILL;
            end
          end
        end
        ST_EMIT_PAD: begin
          if (bus.blk_ready_i) begin
            pad_pending <= 1'b0;
            blk_q       <= '0;
            cnt         <= '0;
            nbytes_q    <= '0;
            last_q      <= 1'b0;
            state       <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_block_packer.sv
// Scoreboard bench for ascon_block_packer: 64- and 128-bit rate instances side by side.
// Builds with or without ASCON_PACKER_NOPAD_EN.
module tb_ascon_block_packer;

  typedef struct packed {
    logic [127:0] blk;
    logic         last;
    logic [4:0]   nb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascon_block_packer_if #(.BLOCK_WIDTH(64))  if64  ();
  ascon_block_packer_if #(.BLOCK_WIDTH(128)) if128 ();

  ascon_block_packer #(.BLOCK_WIDTH(64))  u_dut64  (.clk_i(clk), .rst_ni(rst_n), .bus(if64));
  ascon_block_packer #(.BLOCK_WIDTH(128)) u_dut128 (.clk_i(clk), .rst_ni(rst_n), .bus(if128));

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t q64[$];
  exp_t q128[$];
  logic [1:0] rmode;
  bit   stall_chk;
  logic r64, r128;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit w128, input exp_t e);
    if (w128) q128.push_back(e);
    else      q64.push_back(e);
  endtask

  // Reference: full blocks first, then the padded (or zero-filled) tail block.
  task automatic model(input bit w128, input logic [7:0] msg[$], input bit empty_tail, input bit pad);
    int   nb, len, full, rem;
    exp_t e;
    nb   = w128 ? 16 : 8;
    len  = msg.size();
    full = len / nb;
    rem  = len % nb;
    for (int b = 0; b < full; b++) begin
      e.blk = '0;
      for (int j = 0; j < nb; j++) e.blk[nb*8-1-8*j -: 8] = msg[b*nb+j];
      e.nb   = 5'(nb);
      e.last = !pad && rem == 0 && !empty_tail && b == full - 1;
      push(w128, e);
    end
    if (pad || rem != 0 || len == 0 || empty_tail) begin
      e.blk = '0;
      for (int j = 0; j < rem; j++) e.blk[nb*8-1-8*j -: 8] = msg[full*nb+j];
      if (pad) e.blk[nb*8-1-8*rem -: 8] = 8'h80;
      e.nb   = 5'(rem);
      e.last = 1'b1;
      push(w128, e);
    end
  endtask

  function automatic logic rdy(input bit w128);
    return w128 ? if128.in_ready_o : if64.in_ready_o;
  endfunction

  task automatic drive(input bit w128, input logic v, input logic [7:0] d, input logic l, input logic em);
    if (w128) begin
      if128.in_valid_i = v; if128.in_data_i = d; if128.in_last_i = l; if128.in_empty_i = em;
    end else begin
      if64.in_valid_i = v;  if64.in_data_i = d;  if64.in_last_i = l;  if64.in_empty_i = em;
    end
  endtask

  task automatic set_pad(input bit w128, input bit p);
`ifdef ASCON_PACKER_NOPAD_EN
    if (w128) if128.pad_en_i = p;
    else      if64.pad_en_i = p;
`else
    if (w128 && p) rmode = rmode;
`endif
  endtask

  task automatic send(input bit w128, input logic [7:0] msg[$], input bit empty_tail, input bit pad);
    int beats, wd;
    logic lst, emp;
    logic [7:0] d;
    beats = msg.size() + ((empty_tail || msg.size() == 0) ? 1 : 0);
    model(w128, msg, empty_tail || msg.size() == 0, pad);
    for (int i = 0; i < beats; i++) begin
      lst = (i == beats - 1);
      if (i < msg.size()) begin
        d   = msg[i];
        emp = lst ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        d   = 8'($urandom);
        emp = 1'b1;
      end
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        drive(w128, 1'b0, d, 1'b0, 1'b0);
        @(negedge clk);
      end
      drive(w128, 1'b1, d, lst, emp);
      set_pad(w128, (i == 0) ? pad : 1'($urandom_range(0, 1)));
      wd = 0;
      while (!rdy(w128) && wd < 300) begin
        @(negedge clk);
        wd++;
      end
      chk(w128 ? "in_ready_wait128" : "in_ready_wait64", 128'(rdy(w128)), 128'(1));
      @(posedge clk);
    end
    @(negedge clk);
    drive(w128, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic mon(input bit w128, input logic r);
    exp_t e;
    logic [127:0] b;
    logic lst, irdy;
    logic [4:0] nb;
    int qs;
    if (w128) begin
      b = if128.blk_o; lst = if128.blk_last_o; nb = 5'(if128.blk_nbytes_o); irdy = if128.in_ready_o;
      qs = q128.size();
    end else begin
      b = {64'h0, if64.blk_o}; lst = if64.blk_last_o; nb = 5'(if64.blk_nbytes_o); irdy = if64.in_ready_o;
      qs = q64.size();
    end
    chk(w128 ? "in_ready_emit128" : "in_ready_emit64", 128'(irdy), 128'(0));
    if (r) begin
      if (qs == 0) begin
        chk(w128 ? "sb_underflow128" : "sb_underflow64", 128'(qs), 128'(1));
      end else begin
        if (w128) e = q128.pop_front();
        else      e = q64.pop_front();
        chk(w128 ? "blk128" : "blk64", b, e.blk);
        chk(w128 ? "last128" : "last64", 128'(lst), 128'(e.last));
        chk(w128 ? "nbytes128" : "nbytes64", 128'(nb), 128'(e.nb));
      end
    end else if (stall_chk && qs > 0) begin
      chk(w128 ? "stall_blk128" : "stall_blk64", b, w128 ? q128[0].blk : q64[0].blk);
    end
  endtask

  always @(negedge clk) begin
    r64  = (rmode == 2'd0) ? 1'b1 : (rmode == 2'd1) ? 1'($urandom_range(0, 1)) : 1'b0;
    r128 = (rmode == 2'd0) ? 1'b1 : (rmode == 2'd1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if64.blk_ready_i  = r64;
    if128.blk_ready_i = r128;
    if (rst_n) begin
      if (if64.blk_valid_o)  mon(1'b0, r64);
      if (if128.blk_valid_o) mon(1'b1, r128);
    end
  end

  task automatic drain();
    for (int i = 0; i < 3000 && (q64.size() != 0 || q128.size() != 0); i++) @(negedge clk);
    chk("drain64", 128'(q64.size()), 128'(0));
    chk("drain128", 128'(q128.size()), 128'(0));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid64"},  128'(if64.blk_valid_o),  128'(0));
    chk({tag, "_ready64"},  128'(if64.in_ready_o),   128'(1));
    chk({tag, "_last64"},   128'(if64.blk_last_o),   128'(0));
    chk({tag, "_nbytes64"}, 128'(if64.blk_nbytes_o), 128'(0));
    chk({tag, "_blk64"},    128'(if64.blk_o),        128'(0));
    chk({tag, "_valid128"}, 128'(if128.blk_valid_o), 128'(0));
    chk({tag, "_ready128"}, 128'(if128.in_ready_o),  128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] m[$];
    logic [7:0] m2[$];
    bit pd;
    rst_n = 1'b0;
    rmode = 2'd0;
    stall_chk = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    set_pad(1'b0, 1'b1);
    set_pad(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    send(1'b0, '{8'h01, 8'h02, 8'h03}, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'(i));
    send(1'b0, m, 1'b0, 1'b1);
    m = {};
    send(1'b0, m, 1'b1, 1'b1);
    send(1'b0, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b1, 1'b1);
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'(8'h40 + i));
    send(1'b0, m, 1'b1, 1'b1);
    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'(8'hA0 + i));
    send(1'b1, m, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 16; i++) m.push_back(8'(8'hC0 + i));
    send(1'b1, m, 1'b0, 1'b1);
    m = {};
    send(1'b1, m, 1'b1, 1'b1);
`ifdef ASCON_PACKER_NOPAD_EN
    send(1'b0, '{8'h01, 8'h02, 8'h03}, 1'b0, 1'b0);
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'(i));
    send(1'b0, m, 1'b0, 1'b0);
    send(1'b0, m, 1'b1, 1'b0);
    m = {};
    send(1'b0, m, 1'b1, 1'b0);
    send(1'b1, '{8'hDE, 8'hAD}, 1'b0, 1'b0);
`endif
    drain();

    // backpressure: 10 bytes queued behind a held block
    rmode = 2'd2;
    stall_chk = 1'b1;
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(8'(8'h10 + i));
    fork
      send(1'b0, m, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 100 && !if64.blk_valid_o; i++) @(negedge clk);
        chk("stall_valid64", 128'(if64.blk_valid_o), 128'(1));
        repeat (5) @(negedge clk);
        rmode = 2'd0;
      end
    join
    drain();
    stall_chk = 1'b0;

    // reset while holding a full-last block with padding pending
    rmode = 2'd2;
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'(8'h20 + i));
    send(1'b0, m, 1'b0, 1'b1);
    chk("rst_pre_valid64", 128'(if64.blk_valid_o), 128'(1));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_emit");
    q64.delete();
    rst_n = 1'b1;
    rmode = 2'd0;
    send(1'b0, '{8'hAA, 8'hBB, 8'hCC}, 1'b0, 1'b1);
    drain();

    rmode = 2'd1;
    for (int it = 0; it < 16; it++) begin
      m = {};
      m2 = {};
      for (int j = 0; j < $urandom_range(0, 20); j++) m.push_back(8'($urandom));
      for (int j = 0; j < $urandom_range(0, 36); j++) m2.push_back(8'($urandom));
      pd = 1'b1;
`ifdef ASCON_PACKER_NOPAD_EN
      pd = 1'($urandom_range(0, 1));
`endif
      fork
        send(1'b0, m, 1'($urandom_range(0, 1)), pd);
        send(1'b1, m2, 1'($urandom_range(0, 1)), pd);
      join
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ascon_block_packer.md
Name: ascon_block_packer

Overview:
- Streaming byte-to-block packer with Ascon 10* padding, placed between the byte-wide data interface and the permutation/absorb datapath.
- Collects message bytes MSB-first into rate-sized blocks and pads the final partial block.
- Emits an extra all-padding block when the message length is a multiple of the rate, including the empty message.
- Generalises the single-word combinational padder: parametrised rate (64/128), valid/ready handshakes on both sides, message framing, and byte-count reporting.

Parameters:
- BLOCK_WIDTH, 64, rate in bits; legal values 64 (Ascon-128) or 128 (Ascon-128a); NB = BLOCK_WIDTH/8 bytes.
- CNT_W, $clog2(BLOCK_WIDTH/8)+1, width of byte counters (derived; not to be overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_data_i  in  8  message byte
- in_valid_i  in  1  byte valid
- in_last_i  in  1  final beat of message
- in_empty_i  in  1  qualifies a last beat carrying no byte (empty message or empty tail); ignored unless in_last_i=1
- in_ready_o  out  1  packer accepts a beat
- blk_o  out  BLOCK_WIDTH  padded block, first byte in bits [BLOCK_WIDTH-1 -: 8]
- blk_valid_o  out  1  block valid
- blk_ready_i  in  1  consumer accepts block
- blk_last_o  out  1  block is the final block of the message
- blk_nbytes_o  out  CNT_W  message bytes contained in blk_o (0..NB)

Behaviour:
- Reset (rst_ni=0 at clock edge): state=FILL, byte count=0, buffer=0, blk_valid_o=0, blk_last_o=0, blk_nbytes_o=0, in_ready_o=1 (combinational from state).
- States:
  - FILL: in_ready_o=1, blk_valid_o=0.
  - EMIT: in_ready_o=0, blk_valid_o=1.
  - EMIT_PAD: in_ready_o=0, blk_valid_o=1.
- FILL, beat accepted (in_valid_i & in_ready_o):
  - If not (in_last_i & in_empty_i), write the byte at slot cnt; cnt++.
  - Slot k occupies bits [BLOCK_WIDTH-1-8k -: 8].
- FILL -> EMIT when:
  - cnt reaches NB; blk_last_o=0, or =1 only if in_last_i was set on that beat (see full-last rule below); or
  - in_last_i is accepted with cnt_after < NB: write 0x80 at slot cnt_after, zeros below; blk_last_o=1; blk_nbytes_o=cnt_after.
- Full-last rule: a beat with in_last_i=1 that fills slot NB-1 gives EMIT with blk_last_o=0 and sets pad_pending; next block comes from EMIT_PAD.
- Empty tail: in_last_i & in_empty_i with cnt=0 emits a block of 0x80 followed by zeros, blk_nbytes_o=0, blk_last_o=1.
- EMIT, on blk_ready_i:
  - If pad_pending, go to EMIT_PAD; EMIT_PAD drives blk_o={8'h80, zeros}, blk_nbytes_o=0, blk_last_o=1.
  - Otherwise clear buffer and cnt, return to FILL.
- EMIT_PAD, on blk_ready_i: clear pad_pending, return to FILL.
- Output stability: blk_o, blk_last_o and blk_nbytes_o are registered and held stable while blk_valid_o=1 and blk_ready_i=0.
- Latency: the block is visible the cycle after its completing byte is accepted.
- Throughput: 1 byte/cycle while filling; at least one cycle with in_ready_o=0 per block.
- Unused byte slots are always zero.
- in_empty_i with in_last_i=0: the byte is written normally and in_empty_i has no effect.
- Reset mid-message or mid-EMIT discards all state; no partial block is emitted.

Optional Feature:
- Macro: ASCON_PACKER_NOPAD_EN.
- Defined: adds input pad_en_i (1 bit), sampled per message on the first accepted beat.
  - pad_en_i=0: no 0x80 byte; last partial block is zero-filled with blk_last_o=1.
  - pad_en_i=0 with a full last block: that block carries blk_last_o=1 and no EMIT_PAD block follows.
  - pad_en_i=0 with an empty tail at cnt=0: the all-zero block is still emitted, with blk_nbytes_o=0.
  - Purpose: key/nonce loading.
- Undefined: port absent; padding is always applied.

Decomposition:
- ascon_pack additions:
  - ASCON_PAD_BYTE=8'h80.
  - RATE64=64 and RATE128=128.
  - Enum packer_state_e {FILL, EMIT, EMIT_PAD}.
- One sub-module, ascon_byte_insert: combinational; writes a byte at slot index into a BLOCK_WIDTH vector and zeros the lower slots. It is reused for both data insertion and pad insertion.

Test Plan:
- BLOCK_WIDTH=64, send 3 bytes 0x01,0x02,0x03 with last on the third -> one block 0x0102038000000000, nbytes=3, last=1.
- BLOCK_WIDTH=64, send 8 bytes 0x00..0x07 with last on the eighth -> first block 0x0001020304050607, last=0, nbytes=8; then block 0x8000000000000000, last=1, nbytes=0.
- Empty message (a single beat with last=1, empty=1) -> block 0x80000000_00000000, last=1, nbytes=0.
- BLOCK_WIDTH=128, 20 bytes 0xA0..0xB3 -> block 1 holds 0xA0..0xAF with last=0; block 2 is 0xB0B1B2B3_80000000_00000000_00000000 with last=1, nbytes=4.
- Backpressure: hold blk_ready_i=0 for 5 cycles during EMIT -> blk_o stable, in_ready_o=0, no bytes lost; rst_ni=0 in EMIT -> blk_valid_o=0 next cycle, and the next message starts at slot 0.
- ASCON_PACKER_NOPAD_EN with pad_en_i=0, 8 bytes with last -> a single block, last=1, no pad block; 3 bytes -> 0x0102030000000000.
